// File: rtl/i2s_adc_rx_if.sv
// Stereo sample stream from the I2S ADC receiver toward the capture path.
// The receiver is the master (drives data/valid); the sink is the slave (drives ready).
interface i2s_adc_rx_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] out_left;
  logic [DATA_WIDTH-1:0] out_right;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_left,
    output out_right,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_left,
    input  out_right,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/i2s_adc_rx.sv
// WM8731 ADC-path I2S receiver: synchronizes codec-mastered BCLK/LRCK/DAT, deserializes
// left/right words and buffers complete stereo pairs in a small FIFO with a valid/ready drain.
module i2s_adc_rx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              adc_bclk,
  input  logic              adc_lrck,
  input  logic              adc_dat,
  i2s_adc_rx_if.master      stream,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PairW = 2 * DATA_WIDTH;
  localparam logic [CntW-1:0] FullCnt = CntW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    StSyncWait,
    StLeft,
    StRight
  } state_e;

  // Synchronizers: all three codec lines share the same depth so they stay aligned.
  logic [1:0] bclk_sync;
  logic [1:0] lrck_sync;
  logic [1:0] dat_sync;
  logic       bclk_prev;
  logic       bclk_rise;
  logic       lrck;
  logic       dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], adc_bclk};
      lrck_sync <= {lrck_sync[0], adc_lrck};
      dat_sync  <= {dat_sync[0], adc_dat};
      bclk_prev <= bclk_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_prev;
  assign lrck      = lrck_sync[1];
  assign dat       = dat_sync[1];

  // Deserializer state
  state_e                state_q, state_d;
  logic                  lrck_prev_q, lrck_prev_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic                  pushed_q, pushed_d;
  logic                  push_q, push_d;
  logic [PairW-1:0]      push_data_q, push_data_d;

  logic                  lrck_changed;
  logic                  cnt_room;
  logic [CntW-1:0]       bit_pos;
  logic [DATA_WIDTH-1:0] shift_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StSyncWait;
      lrck_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_q      <= '0;
      pushed_q    <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      lrck_prev_q <= lrck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      pushed_q    <= pushed_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lrck_prev_d = lrck_prev_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_d      = left_q;
    pushed_d    = pushed_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;

    lrck_changed = lrck ^ lrck_prev_q;
    cnt_room     = bit_cnt_q < FullCnt;
    bit_pos      = FullCnt - CntW'(1) - bit_cnt_q;
    // Bits land at their final MSB-first position, so a short word is already left-aligned.
    shift_in     = shift_q | ({{(DATA_WIDTH-1){1'b0}}, dat} << bit_pos);

    if (!enable) begin
      state_d  = StSyncWait;
      pushed_d = 1'b0;
      if (bclk_rise) begin
        lrck_prev_d = lrck;
      end
    end else if (bclk_rise) begin
      lrck_prev_d = lrck;
      unique case (state_q)
        StSyncWait: begin
          if (!lrck && lrck_prev_q) begin
            state_d   = StLeft;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        StLeft: begin
          if (lrck_changed) begin
            left_d    = shift_q;
            shift_d   = '0;
            bit_cnt_d = '0;
            pushed_d  = 1'b0;
            state_d   = StRight;
          end else if (cnt_room) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StRight: begin
          if (lrck_changed) begin
            if (!pushed_q) begin
              push_d      = 1'b1;
              push_data_d = {left_q, shift_q};
            end
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = StLeft;
          end else if (cnt_room) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + CntW'(1);
            // Push as soon as the right word is complete; the LRCK change then skips it.
            if (!pushed_q && (bit_cnt_q == FullCnt - CntW'(1))) begin
              push_d      = 1'b1;
              push_data_d = {left_q, shift_in};
              pushed_d    = 1'b1;
            end
          end
        end
        default: state_d = StSyncWait;
      endcase
    end
  end

  // Pair FIFO
  logic [PairW-1:0] mem [FIFO_DEPTH];
  logic [PtrW:0]    wr_ptr_q;
  logic [PtrW:0]    rd_ptr_q;
  logic [PairW-1:0] last_q;
  logic [PairW-1:0] head;
  logic [PairW-1:0] shown;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  // A pop in the same cycle does not make room for a push into a full FIFO.
  assign do_push = push_q & ~full;
  assign do_pop  = ~empty & stream.out_ready;
  assign head    = mem[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= head;
      end
      if (push_q && full) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[PtrW-1:0]] <= push_data_q;
    end
  end

  // When empty, keep presenting the most recently popped pair.
  assign shown            = empty ? last_q : head;
  assign stream.out_valid = ~empty;
  assign stream.out_left  = shown[PairW-1:DATA_WIDTH];
  assign stream.out_right = shown[DATA_WIDTH-1:0];

endmodule
